// File: rtl/scc_slot_interface.sv
// scc_slot_interface: MSX cartridge-slot front end for the SCC sound core.
// Synchronises the slot strobes, qualifies memory / I/O cycles, waits a
// settle time and then hands one-cycle rd/wr requests with latched address
// and data to the core. Read data from the core is held for the slot.
module scc_slot_interface #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned SAMPLE_DELAY = 2,
  parameter int unsigned ADDR_W       = 15,
  parameter bit          IO_ENABLE    = 1'b0,
  parameter logic [7:0]  IO_PORT      = 8'hA0,
  parameter logic [7:0]  IO_MASK      = 8'hFE
) (
  input  logic              clk,
  input  logic              slot_nreset,
  input  logic [ADDR_W-1:0] slot_a,
  input  logic [7:0]        slot_d_in,
  output logic [7:0]        slot_d_out,
  output logic              slot_d_oe,
  input  logic              slot_nsltsl,
  input  logic              slot_nmerq,
  input  logic              slot_niorq,
  input  logic              slot_nrd,
  input  logic              slot_nwr,
  output logic              mem_ncs,
  output logic              core_wrreq,
  output logic              core_rdreq,
  output logic              core_io,
  output logic [ADDR_W-1:0] core_a,
  output logic [7:0]        core_d,
  input  logic [7:0]        core_q,
  input  logic              core_q_valid,
  input  logic              core_claim,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SETTLE, ISSUE, HOLD} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SAMPLE_DELAY);

  logic [SYNC_STAGES-1:0] nrd_sync;
  logic [SYNC_STAGES-1:0] nwr_sync;
  logic [SYNC_STAGES-1:0] niorq_sync;
  logic                   nrd_s;
  logic                   nwr_s;
  logic                   niorq_s;
  logic                   nrd_s_d;
  logic                   nwr_s_d;

  logic                   port_match;
  logic                   mem_cyc;
  logic                   io_cyc;
  logic                   rd_fall;
  logic                   wr_fall;
  logic                   both_low;
  logic                   start;
  logic                   act_high;
  logic                   issue_now;
  logic                   issue_write;

  state_t                 state;
  logic [3:0]             settle_cnt;
  logic                   is_write;
  logic                   rd_valid;

  assign nrd_s   = nrd_sync[SYNC_STAGES-1];
  assign nwr_s   = nwr_sync[SYNC_STAGES-1];
  assign niorq_s = niorq_sync[SYNC_STAGES-1];

  // Strobe synchronisers plus one extra stage for edge detection.
  always_ff @(posedge clk or negedge slot_nreset) begin
    if (!slot_nreset) begin
      nrd_sync   <= '1;
      nwr_sync   <= '1;
      niorq_sync <= '1;
      nrd_s_d    <= 1'b1;
      nwr_s_d    <= 1'b1;
    end else begin
      nrd_sync   <= {nrd_sync[SYNC_STAGES-2:0], slot_nrd};
      nwr_sync   <= {nwr_sync[SYNC_STAGES-2:0], slot_nwr};
      niorq_sync <= {niorq_sync[SYNC_STAGES-2:0], slot_niorq};
      nrd_s_d    <= nrd_s;
      nwr_s_d    <= nwr_s;
    end
  end

  // Cycle qualification, strobe edges and the decision to issue this edge.
  always_comb begin
    port_match  = ((slot_a[7:0] ^ IO_PORT) & IO_MASK) == 8'h00;
    mem_cyc     = ~slot_nsltsl & ~slot_nmerq;
    io_cyc      = IO_ENABLE & ~niorq_s & port_match;
    rd_fall     = nrd_s_d & ~nrd_s;
    wr_fall     = nwr_s_d & ~nwr_s;
    both_low    = ~nrd_s & ~nwr_s;
    start       = (rd_fall | wr_fall) & ~both_low & (mem_cyc | io_cyc);
    act_high    = is_write ? nwr_s : nrd_s;
    issue_now   = 1'b0;
    issue_write = is_write;
    // Requests are registered on entry to ISSUE, so the issue decision is
    // taken one count early (count 1 in SETTLE, or straight from IDLE when
    // there is no settle time) to keep latency at SYNC_STAGES+SAMPLE_DELAY.
    case (state)
      IDLE: begin
        issue_now   = start && (SAMPLE_DELAY == 0);
        issue_write = wr_fall;
      end
      SETTLE: issue_now = ~act_high && (settle_cnt <= 4'd1);
      default: ;
    endcase
  end

  // Main sequencer: settle, issue one request, hold until the strobe ends.
  always_ff @(posedge clk or negedge slot_nreset) begin
    if (!slot_nreset) begin
      state      <= IDLE;
      settle_cnt <= '0;
      is_write   <= 1'b0;
      rd_valid   <= 1'b0;
      core_wrreq <= 1'b0;
      core_rdreq <= 1'b0;
      core_io    <= 1'b0;
      core_a     <= '0;
      core_d     <= '0;
      slot_d_out <= '0;
    end else begin
      core_wrreq <= 1'b0;
      core_rdreq <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_write   <= wr_fall;
            settle_cnt <= SETTLE_LOAD;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (act_high) begin
            state <= IDLE;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        ISSUE: state <= HOLD;
        HOLD: begin
          if (!is_write && core_q_valid && !rd_valid) begin
            rd_valid   <= 1'b1;
            slot_d_out <= core_q;
          end
          if (act_high) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (issue_now) begin
        state      <= ISSUE;
        is_write   <= issue_write;
        core_wrreq <= issue_write;
        core_rdreq <= ~issue_write;
        core_a     <= slot_a;
        core_d     <= slot_d_in;
        core_io    <= io_cyc;
        rd_valid   <= 1'b0;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign slot_d_oe = ~is_write & (state == HOLD) & rd_valid & core_claim &
                     ~slot_nrd & (mem_cyc | io_cyc);
  assign mem_ncs   = slot_nsltsl | slot_nmerq | core_claim;

endmodule

// File: tb/tb_scc_slot_interface.sv
// Bench for scc_slot_interface: two instances (default timing with I/O
// disabled, and 3-stage sync / no settle with I/O enabled) share one slot
// bus and are compared every cycle against a cycle-indexed reference model.
module tb_scc_slot_interface;

  logic        clk;
  logic        nreset;
  logic [14:0] a;
  logic [7:0]  din;
  logic        nsltsl, nmerq, niorq, nrd, nwr;
  logic [7:0]  cq;
  logic        cqv, claim;

  logic [7:0]  dout [2];
  logic        doe  [2];
  logic        ncs  [2];
  logic        wrq  [2];
  logic        rdq  [2];
  logic        cio  [2];
  logic        bsy  [2];
  logic [14:0] ca   [2];
  logic [7:0]  cd   [2];

  scc_slot_interface #(.SYNC_STAGES(2), .SAMPLE_DELAY(2), .ADDR_W(15),
                       .IO_ENABLE(1'b0), .IO_PORT(8'hA0), .IO_MASK(8'hFE)) u_dut0 (
    .clk(clk), .slot_nreset(nreset), .slot_a(a), .slot_d_in(din),
    .slot_d_out(dout[0]), .slot_d_oe(doe[0]), .slot_nsltsl(nsltsl),
    .slot_nmerq(nmerq), .slot_niorq(niorq), .slot_nrd(nrd), .slot_nwr(nwr),
    .mem_ncs(ncs[0]), .core_wrreq(wrq[0]), .core_rdreq(rdq[0]),
    .core_io(cio[0]), .core_a(ca[0]), .core_d(cd[0]), .core_q(cq),
    .core_q_valid(cqv), .core_claim(claim), .busy(bsy[0]));

  scc_slot_interface #(.SYNC_STAGES(3), .SAMPLE_DELAY(0), .ADDR_W(15),
                       .IO_ENABLE(1'b1), .IO_PORT(8'hA0), .IO_MASK(8'hFE)) u_dut1 (
    .clk(clk), .slot_nreset(nreset), .slot_a(a), .slot_d_in(din),
    .slot_d_out(dout[1]), .slot_d_oe(doe[1]), .slot_nsltsl(nsltsl),
    .slot_nmerq(nmerq), .slot_niorq(niorq), .slot_nrd(nrd), .slot_nwr(nwr),
    .mem_ncs(ncs[1]), .core_wrreq(wrq[1]), .core_rdreq(rdq[1]),
    .core_io(cio[1]), .core_a(ca[1]), .core_d(cd[1]), .core_q(cq),
    .core_q_valid(cqv), .core_claim(claim), .busy(bsy[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  // ---------------- bookkeeping ----------------
  int n_chk  = 0;
  int n_fail = 0;
  int req_cnt [2] = '{0, 0};
  int req_cyc [2] = '{0, 0};
  int last_n = 0;
  bit rand_core = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Raw strobe samples indexed by posedge number since reset release. The
  // sequencer of an instance with S sync stages sees at posedge t the raw
  // value sampled at posedge t-S; anything before reset release reads high.
  int cfg_ss [2] = '{2, 3};
  int cfg_dl [2] = '{2, 0};
  bit cfg_io [2] = '{1'b0, 1'b1};

  bit h_rd [$];
  bit h_wr [$];
  bit h_io [$];
  int cyc = 0;

  bit          m_busy   [2];
  bit          m_issued [2];
  bit          m_kind   [2];   // 1 = write
  int          m_at     [2];   // posedge of the request pulse
  bit          m_lv     [2];
  logic [7:0]  e_dout   [2];
  logic [14:0] e_a      [2];
  logic [7:0]  e_d      [2];
  bit          e_io     [2];
  bit          e_wrq    [2];
  bit          e_rdq    [2];

  function automatic bit hist(input int which, input int idx);
    if (idx < 0) return 1'b1;
    case (which)
      0:       return h_rd[idx];
      1:       return h_wr[idx];
      default: return h_io[idx];
    endcase
  endfunction

  task automatic model_reset();
    h_rd.delete(); h_wr.delete(); h_io.delete();
    cyc = 0;
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_issued[k] = 0; m_kind[k] = 0; m_at[k] = 0; m_lv[k] = 0;
      e_dout[k] = '0; e_a[k] = '0; e_d[k] = '0; e_io[k] = 0;
      e_wrq[k] = 0; e_rdq[k] = 0;
    end
  endtask

  task automatic model_step();
    bit rs, rp, ws, wp, ios, sel, pio, strobe;
    int s;
    h_rd.push_back(nrd); h_wr.push_back(nwr); h_io.push_back(niorq);
    for (int k = 0; k < 2; k++) begin
      s   = cfg_ss[k];
      rs  = hist(0, cyc - s);  rp = hist(0, cyc - s - 1);
      ws  = hist(1, cyc - s);  wp = hist(1, cyc - s - 1);
      ios = hist(2, cyc - s);
      sel = !nsltsl && !nmerq;
      pio = cfg_io[k] && !ios && (a[7:1] == 7'h50);
      strobe = m_kind[k] ? ws : rs;
      e_wrq[k] = 0; e_rdq[k] = 0;
      if (!m_busy[k]) begin
        if (((rp && !rs) || (wp && !ws)) && (rs || ws) && (sel || pio)) begin
          m_busy[k] = 1; m_issued[k] = 0;
          m_kind[k] = wp && !ws;
          m_at[k]   = cyc + cfg_dl[k];
        end
      end else if (!m_issued[k]) begin
        if (strobe) m_busy[k] = 0;
      end else if (cyc >= m_at[k] + 2) begin
        if (!m_kind[k] && cqv && !m_lv[k]) begin
          m_lv[k] = 1; e_dout[k] = cq;
        end
        if (strobe) m_busy[k] = 0;
      end
      if (m_busy[k] && !m_issued[k] && cyc == m_at[k]) begin
        m_issued[k] = 1;
        e_wrq[k] = m_kind[k]; e_rdq[k] = !m_kind[k];
        e_a[k] = a; e_d[k] = din; e_io[k] = pio; m_lv[k] = 0;
      end
    end
    cyc++;
  endtask

  task automatic check_all();
    bit pio_now, oe_exp;
    int t;
    t = cyc - 1;
    for (int k = 0; k < 2; k++) begin
      pio_now = cfg_io[k] && !hist(2, t - cfg_ss[k] + 1) && (a[7:1] == 7'h50);
      oe_exp  = m_busy[k] && m_issued[k] && (t >= m_at[k] + 1) && !m_kind[k] &&
                m_lv[k] && claim && !nrd && ((!nsltsl && !nmerq) || pio_now);
      chk($sformatf("wrreq%0d@%0d", k, t), wrq[k], e_wrq[k]);
      chk($sformatf("rdreq%0d@%0d", k, t), rdq[k], e_rdq[k]);
      chk($sformatf("busy%0d@%0d", k, t), bsy[k], m_busy[k]);
      chk($sformatf("core_a%0d@%0d", k, t), ca[k], e_a[k]);
      chk($sformatf("core_d%0d@%0d", k, t), cd[k], e_d[k]);
      chk($sformatf("core_io%0d@%0d", k, t), cio[k], e_io[k]);
      chk($sformatf("d_oe%0d@%0d", k, t), doe[k], oe_exp);
      chk($sformatf("d_out%0d@%0d", k, t), dout[k], e_dout[k]);
      chk($sformatf("mem_ncs%0d@%0d", k, t), ncs[k], nsltsl | nmerq | claim);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    for (int k = 0; k < 2; k++) begin
      if (wrq[k] || rdq[k]) begin
        req_cnt[k]++;
        req_cyc[k] = cyc - 1;
      end
    end
    if (rand_core) begin
      claim = 1'($urandom);
      cqv   = ($urandom_range(0, 3) == 0);
      cq    = 8'($urandom);
    end
  endtask

  task automatic chk_reset(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_wrreq%0d", tag, k), wrq[k], 0);
      chk($sformatf("%s_rdreq%0d", tag, k), rdq[k], 0);
      chk($sformatf("%s_busy%0d", tag, k), bsy[k], 0);
      chk($sformatf("%s_core_a%0d", tag, k), ca[k], 0);
      chk($sformatf("%s_core_d%0d", tag, k), cd[k], 0);
      chk($sformatf("%s_core_io%0d", tag, k), cio[k], 0);
      chk($sformatf("%s_d_oe%0d", tag, k), doe[k], 0);
      chk($sformatf("%s_d_out%0d", tag, k), dout[k], 0);
    end
  endtask

  task automatic bus_idle();
    nrd = 1; nwr = 1; niorq = 1; nmerq = 1; nsltsl = 1;
  endtask

  // One slot cycle: qualifiers and strobe low for low_cycles posedges.
  task automatic bus_cycle(input bit wr, input bit io, input logic [14:0] addr,
                           input logic [7:0] data, input bit sel,
                           input int low_cycles, input int gap);
    a = addr; din = data;
    if (io) begin niorq = 0; nsltsl = 1; nmerq = 1; end
    else    begin niorq = 1; nsltsl = !sel; nmerq = 0; end
    if (wr) nwr = 0; else nrd = 0;
    last_n = cyc;
    repeat (low_cycles) tick();
    bus_idle();
    repeat (gap) tick();
  endtask

  typedef struct {
    logic nsltsl;
    logic nmerq;
    logic claim;
    logic exp_ncs;
  } ncs_vec_t;

  ncs_vec_t ncs_tab [8];

  initial begin
    int c0, c1;
    bit seen;

    ncs_tab[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    ncs_tab[1] = '{1'b0, 1'b0, 1'b1, 1'b1};
    ncs_tab[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
    ncs_tab[3] = '{1'b0, 1'b1, 1'b1, 1'b1};
    ncs_tab[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    ncs_tab[5] = '{1'b1, 1'b0, 1'b1, 1'b1};
    ncs_tab[6] = '{1'b1, 1'b1, 1'b0, 1'b1};
    ncs_tab[7] = '{1'b1, 1'b1, 1'b1, 1'b1};

    nreset = 0; a = '0; din = '0; cq = '0; cqv = 0; claim = 0;
    bus_idle();
    model_reset();
    #3;
    chk_reset("por");
    repeat (3) @(posedge clk);
    @(negedge clk);
    nreset = 1;

    // mem_ncs decode table
    for (int i = 0; i < 8; i++) begin
      nsltsl = ncs_tab[i].nsltsl; nmerq = ncs_tab[i].nmerq; claim = ncs_tab[i].claim;
      #1;
      for (int k = 0; k < 2; k++)
        chk($sformatf("ncs_tab%0d_dut%0d", i, k), ncs[k], ncs_tab[i].exp_ncs);
    end
    bus_idle(); claim = 0;
    repeat (4) tick();

    // 1: memory write, latency and latched values
    c0 = req_cnt[0]; c1 = req_cnt[1];
    bus_cycle(1, 0, 15'h5800, 8'h3C, 1, 6, 6);
    chk("t1_wr_count0", req_cnt[0] - c0, 1);
    chk("t1_wr_count1", req_cnt[1] - c1, 1);
    chk("t1_latency0", req_cyc[0] - last_n, 4);
    chk("t1_latency1", req_cyc[1] - last_n, 3);
    chk("t1_core_a", ca[0], 15'h5800);
    chk("t1_core_d", cd[0], 8'h3C);
    chk("t1_core_io", cio[0], 0);

    // 2: memory read, core data returned one cycle after the request
    claim = 1; cq = 8'hA5; cqv = 0;
    a = 15'h5880; nsltsl = 0; nmerq = 0; nrd = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (rdq[0]) seen = 1;
    end
    chk("t2_rdreq_seen", seen, 1);
    tick();
    cqv = 1;
    tick();
    cqv = 0; cq = 8'h00;
    chk("t2_d_oe", doe[0], 1);
    chk("t2_d_out", dout[0], 8'hA5);
    chk("t2_mem_ncs", ncs[0], 1);
    tick();
    nrd = 1;
    #1;
    chk("t2_d_oe_drop", doe[0], 0);
    bus_idle(); claim = 0;
    repeat (6) tick();

    // 3: short write pulse released while settling
    c0 = req_cnt[0];
    bus_cycle(1, 0, 15'h1234, 8'h55, 1, 2, 6);
    chk("t3_no_req0", req_cnt[0] - c0, 0);
    chk("t3_busy0", bsy[0], 0);

    // 4: I/O writes, matching and non-matching port
    c0 = req_cnt[0]; c1 = req_cnt[1];
    bus_cycle(1, 1, 15'h00A1, 8'h77, 0, 6, 6);
    chk("t4_io_count1", req_cnt[1] - c1, 1);
    chk("t4_core_io1", cio[1], 1);
    chk("t4_io_disabled0", req_cnt[0] - c0, 0);
    c0 = req_cnt[0]; c1 = req_cnt[1];
    bus_cycle(1, 1, 15'h00A2, 8'h78, 0, 6, 6);
    chk("t4_nomatch0", req_cnt[0] - c0, 0);
    chk("t4_nomatch1", req_cnt[1] - c1, 0);

    // 5: both strobes together, then a legal write
    c0 = req_cnt[0]; c1 = req_cnt[1];
    a = 15'h4000; din = 8'h11; nsltsl = 0; nmerq = 0; nrd = 0; nwr = 0;
    repeat (6) tick();
    bus_idle();
    repeat (6) tick();
    chk("t5_illegal0", req_cnt[0] - c0, 0);
    chk("t5_illegal1", req_cnt[1] - c1, 0);
    bus_cycle(1, 0, 15'h4001, 8'h22, 1, 6, 6);
    chk("t5_legal0", req_cnt[0] - c0, 1);
    chk("t5_legal1", req_cnt[1] - c1, 1);

    // 6: reset while settling, then a normal write
    a = 15'h7000; din = 8'h99; nsltsl = 0; nmerq = 0; nwr = 0;
    repeat (3) tick();
    chk("t6_in_settle", bsy[0], 1);
    nreset = 0;
    #1;
    chk_reset("t6");
    bus_idle();
    c0 = req_cnt[0]; c1 = req_cnt[1];
    repeat (2) @(posedge clk);
    @(negedge clk);
    nreset = 1;
    model_reset();
    repeat (10) tick();
    chk("t6_no_stray0", req_cnt[0] - c0, 0);
    chk("t6_no_stray1", req_cnt[1] - c1, 0);
    bus_cycle(1, 0, 15'h7001, 8'h9A, 1, 6, 6);
    chk("t6_latency0", req_cyc[0] - last_n, 4);
    chk("t6_latency1", req_cyc[1] - last_n, 3);

    // randomized slot traffic against the model
    rand_core = 1;
    for (int i = 0; i < 80; i++) begin
      logic [14:0] ra;
      int sel_port;
      ra = 15'($urandom);
      sel_port = $urandom_range(0, 3);
      if (sel_port == 0) ra[7:0] = 8'hA0;
      else if (sel_port == 1) ra[7:0] = 8'hA1;
      else if (sel_port == 2) ra[7:0] = 8'hA2;
      bus_cycle(1'($urandom), $urandom_range(0, 2) == 0, ra, 8'($urandom),
                $urandom_range(0, 4) != 0, $urandom_range(1, 8), $urandom_range(1, 5));
    end
    rand_core = 0; claim = 0; cqv = 0;
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
